// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the ID/EX register and the EX datapath.
// Forwarding sources and pipeline controls travel with it.
interface id_ex_stage_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic [31:0] in_rd1;
  logic [31:0] in_rd2;
  logic [31:0] in_imm;
  logic [4:0]  in_aluop;
  logic        in_alusrc;
  logic        in_regwrite;
  logic        in_memread;
  logic        in_memwrite;
  logic        in_branch;
  logic        flush;
  logic        hold;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_aluop;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [31:0] ex_store_data;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
           in_rd1, in_rd2, in_imm, in_aluop, in_alusrc, in_regwrite,
           in_memread, in_memwrite, in_branch, flush, hold,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  stall, ex_valid, ex_pc, ex_rd, ex_aluop, ex_regwrite, ex_memread,
           ex_memwrite, ex_branch, ex_A, ex_B, ex_store_data
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_use_rs1, in_use_rs2,
           in_rd1, in_rd2, in_imm, in_aluop, in_alusrc, in_regwrite,
           in_memread, in_memwrite, in_branch, flush, hold,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output stall, ex_valid, ex_pc, ex_rd, ex_aluop, ex_regwrite, ex_memread,
           ex_memwrite, ex_branch, ex_A, ex_B, ex_store_data
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB
// operand forwarding feeding the ALU operand muxes.
module id_ex_stage (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  localparam logic [4:0] aluop_nop = 5'd0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  aluop;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
  } stage_t;

  function automatic stage_t bubble();
    stage_t b;
    b       = '0;
    b.aluop = aluop_nop;
    return b;
  endfunction

  stage_t      stage_q;
  stage_t      stage_d;
  stage_t      load_s;
  logic        hz;
  logic        exmem_hit1;
  logic        exmem_hit2;
  logic        memwb_hit1;
  logic        memwb_hit2;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // Stall handshake: stall is a same-cycle request; upstream must keep in_*
  // stable while it is high. The bubble clears ex_memread, so hz (and stall)
  // drops after one edge unless hold keeps the load frozen in EX.
  always_comb begin
    hz = stage_q.valid && stage_q.memread && (stage_q.rd != 5'd0) && bus.in_valid &&
         ((bus.in_use_rs1 && (bus.in_rs1 == stage_q.rd)) ||
          (bus.in_use_rs2 && (bus.in_rs2 == stage_q.rd)));
  end

  assign bus.stall = hz && !bus.flush;

  always_comb begin
    load_s          = '0;
    load_s.valid    = bus.in_valid;
    load_s.pc       = bus.in_pc;
    load_s.rs1      = bus.in_rs1;
    load_s.rs2      = bus.in_rs2;
    load_s.rd       = bus.in_rd;
    load_s.rd1      = bus.in_rd1;
    load_s.rd2      = bus.in_rd2;
    load_s.imm      = bus.in_imm;
    load_s.aluop    = bus.in_aluop;
    load_s.alusrc   = bus.in_alusrc;
    load_s.regwrite = bus.in_regwrite;
    load_s.memread  = bus.in_memread;
    load_s.memwrite = bus.in_memwrite;
    load_s.branch   = bus.in_branch;
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.flush)     stage_d = bubble();
    else if (bus.hold) stage_d = stage_q;
    else if (hz)       stage_d = bubble();
    else               stage_d = load_s;
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= bubble();
    else     stage_q <= stage_d;
  end

  // A bubble (valid=0) passes raw register values; x0 never matches.
  always_comb begin
    exmem_hit1 = stage_q.valid && bus.exmem_regwrite && (bus.exmem_rd != 5'd0) &&
                 (bus.exmem_rd == stage_q.rs1);
    exmem_hit2 = stage_q.valid && bus.exmem_regwrite && (bus.exmem_rd != 5'd0) &&
                 (bus.exmem_rd == stage_q.rs2);
    memwb_hit1 = stage_q.valid && bus.memwb_regwrite && (bus.memwb_rd != 5'd0) &&
                 (bus.memwb_rd == stage_q.rs1);
    memwb_hit2 = stage_q.valid && bus.memwb_regwrite && (bus.memwb_rd != 5'd0) &&
                 (bus.memwb_rd == stage_q.rs2);

    fwd_rs1 = stage_q.rd1;
    if (exmem_hit1)      fwd_rs1 = bus.exmem_result;
    else if (memwb_hit1) fwd_rs1 = bus.memwb_result;

    fwd_rs2 = stage_q.rd2;
    if (exmem_hit2)      fwd_rs2 = bus.exmem_result;
    else if (memwb_hit2) fwd_rs2 = bus.memwb_result;
  end

  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_pc         = stage_q.pc;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_aluop      = stage_q.aluop;
  assign bus.ex_regwrite   = stage_q.regwrite;
  assign bus.ex_memread    = stage_q.memread;
  assign bus.ex_memwrite   = stage_q.memwrite;
  assign bus.ex_branch     = stage_q.branch;
  assign bus.ex_A          = fwd_rs1;
  assign bus.ex_B          = stage_q.alusrc ? stage_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
endmodule
